timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Multi-channel, parametrised successor to the free-running counter.
- Provides NUM_CHANNELS independent counters, each with:
  - enable and up/down direction
  - a per-channel prescaler
  - wrap, saturate or one-shot terminal mode
  - a compare-match pulse and a sticky terminal flag
- Configured through a single-cycle register write port.
- Sits beside the CPU bus as a timer/interrupt source; a combined irq output feeds the interrupt controller.

Parameters:
- NUM_CHANNELS, 4, number of independent counter channels (1..16).
- COUNTER_BIT_WIDTH, 32, width of each counter, compare and load value.
- PRESCALER_BIT_WIDTH, 16, width of each channel's prescale divider.
- CH_W, $clog2(NUM_CHANNELS) (min 1), derived localparam, channel-select width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_ch  in  CH_W  target channel.
- wr_addr  in  2  0=CTRL, 1=LOAD, 2=COMPARE, 3=PRESCALE.
- wr_data  in  COUNTER_BIT_WIDTH  write data.
- flag_clr  in  NUM_CHANNELS  per-channel clear of the sticky terminal flag.
- count_out  out  NUM_CHANNELS*COUNTER_BIT_WIDTH  packed counter values; channel i at [i*W +: W].
- match  out  NUM_CHANNELS  one-cycle compare-match pulses.
- term_flag  out  NUM_CHANNELS  sticky terminal-event flags.
- irq  out  1  OR over channels of (term_flag[i] & ctrl.irq_en).

Behaviour:
- Reset (rst low, async):
  - All counters, compare and prescale registers = 0.
  - CTRL = 0 (disabled, up, wrap, irq off).
  - match, term_flag, irq = 0.
  - Prescale counters = 0.
- CTRL bit fields:
  - [0] enable
  - [1] down
  - [3:2] mode: 00 wrap, 01 saturate, 10 one-shot; 11 is reserved and behaves as wrap.
  - [4] irq_en
  - Upper bits are ignored.
- Writes:
  - Take effect on the posedge where wr_en=1.
  - Writes with wr_ch >= NUM_CHANNELS are ignored.
  - PRESCALE takes wr_data[PRESCALER_BIT_WIDTH-1:0].
- Prescaler:
  - While enabled, the prescale counter increments each cycle.
  - A tick is produced when it equals PRESCALE, after which it returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - The prescale counter resets to 0 on disable, on a LOAD write, and on a PRESCALE write.
- Step on tick:
  - up: count+1; down: count-1.
  - Terminal value: 2^W-1 when up, 0 when down.
  - A terminal event is a tick while count == terminal.
- On a terminal event, by mode:
  - wrap: count goes to 0 (up) or 2^W-1 (down).
  - saturate: count holds.
  - one-shot: count holds and CTRL.enable clears the same cycle.
  - In every mode, term_flag sets.
- Latency:
  - With PRESCALE=0 and enable written at edge E, count_out = N after edge E+N.
  - This preserves the legacy counter behaviour: N cycles after start, the count reads N.
- match[i]:
  - Registered; high for exactly the one cycle following an edge where a tick moved count to a value equal to COMPARE.
  - A LOAD equal to COMPARE does not pulse.
  - A COMPARE write equal to the current count does not pulse.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the LOAD wins and no step occurs.
  - CTRL write and a one-shot terminal in the same cycle: the CTRL write wins.
  - flag_clr and a terminal event in the same cycle: set wins (flag stays 1).
- Reset mid-operation: asynchronous return to reset values, with no further match pulse.
- Channels are fully independent; there is no cross-channel interaction other than irq.

Decomposition:
- Package timer_bank_pkg holds:
  - the wr_addr enum (ADDR_CTRL, ADDR_LOAD, ADDR_COMPARE, ADDR_PRESCALE)
  - the mode enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT)
  - a packed ctrl_t struct (irq_en, mode, down, enable)
- Sub-module timer_channel: one counter, prescaler, compare, flag and ctrl register, parametrised by the widths.
- timer_bank contains:
  - the generate loop over channels
  - write decode (wr_en & wr_ch==i)
  - the count_out packing
  - the irq OR

Test Plan:
1. Basic count: reset; CTRL ch0 = enable, up, wrap; PRESCALE=0; wait 100 cycles -> count_out[ch0]=100; other channels stay 0.
2. Wrap up: COUNTER_BIT_WIDTH=8 build; LOAD=0xFE; enable up/wrap.
   - Counts 0xFF, then 0x00.
   - term_flag[0]=1 from the wrap edge.
   - irq=1 only if irq_en is set.
   - flag_clr[0] pulse -> 0.
3. One-shot down: LOAD=3; CTRL = enable, down, one-shot; PRESCALE=0.
   - Counts 2, 1, 0, then holds 0.
   - CTRL.enable reads 0 afterwards.
   - term_flag set once.
4. Prescale and match: PRESCALE=4; COMPARE=3; enable up.
   - count increments every 5 cycles.
   - match pulses exactly one cycle after the step to 3 (cycle ~15).
   - No further pulses until wrap.
5. Simultaneous events:
   - LOAD=50 on the same edge as a tick -> count=50, no step.
   - flag_clr on the same cycle as a saturate terminal -> term_flag=1.
6. Async reset mid-count: deassert clocks, pulse rst low between edges -> all outputs 0 immediately; counting resumes from 0 only after re-enable.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared types for the timer bank: register map, terminal modes, CTRL layout.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        ADDR_CTRL     = 2'd0,
        ADDR_LOAD     = 2'd1,
        ADDR_COMPARE  = 2'd2,
        ADDR_PRESCALE = 2'd3
    } addr_e;

    // Encoding 2'b11 is reserved and is treated as wrap.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    // Bit layout matches the CTRL register: [4] irq_en, [3:2] mode, [1] down, [0] enable.
    typedef struct packed {
        logic  irq_en;
        mode_e mode;
        logic  down;
        logic  enable;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up/down counter with terminal handling,
// compare-match pulse, sticky terminal flag and its own CTRL register.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CW = 32,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_sel,
    input  logic [1:0]    wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic          flag_clr,
    output logic [CW-1:0] count,
    output logic          match,
    output logic          term_flag,
    output logic          irq_src
);

    ctrl_t         ctrl;
    logic [CW-1:0] compare;
    logic [PW-1:0] prescale;
    logic [PW-1:0] pcnt;

    logic          ctrl_wr, load_wr, cmp_wr, pre_wr;
    logic          tick, at_term, hold_mode, terminal, moved;
    logic [CW-1:0] step_val, count_nxt;
    logic [PW-1:0] pcnt_nxt;

    // Next-state for counter and prescaler; a LOAD write pre-empts any step.
    always_comb begin
        ctrl_wr   = wr_sel && (wr_addr == ADDR_CTRL);
        load_wr   = wr_sel && (wr_addr == ADDR_LOAD);
        cmp_wr    = wr_sel && (wr_addr == ADDR_COMPARE);
        pre_wr    = wr_sel && (wr_addr == ADDR_PRESCALE);
        tick      = ctrl.enable && (pcnt == prescale);
        at_term   = ctrl.down ? (count == '0) : (count == '1);
        hold_mode = (ctrl.mode == MODE_SAT) || (ctrl.mode == MODE_ONESHOT);
        // Modular step also produces the wrap value at the terminal.
        step_val  = ctrl.down ? count - CW'(1) : count + CW'(1);
        terminal  = tick && at_term && !load_wr;
        moved     = tick && !load_wr && !(at_term && hold_mode);
        count_nxt = count;
        if (load_wr)
            count_nxt = wr_data;
        else if (moved)
            count_nxt = step_val;
        pcnt_nxt = pcnt + PW'(1);
        if (!ctrl.enable || load_wr || pre_wr || tick)
            pcnt_nxt = '0;
    end

    // Counter, prescale counter and match pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            pcnt  <= '0;
            match <= 1'b0;
        end else begin
            count <= count_nxt;
            pcnt  <= pcnt_nxt;
            match <= moved && (count_nxt == compare);
        end
    end

    // Configuration registers; a CTRL write beats the one-shot self-disable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl     <= '0;
            compare  <= '0;
            prescale <= '0;
        end else begin
            if (ctrl_wr)
                ctrl <= ctrl_t'(wr_data[CTRL_W-1:0]);
            else if (terminal && ctrl.mode == MODE_ONESHOT)
                ctrl.enable <= 1'b0;
            if (cmp_wr)
                compare <= wr_data;
            if (pre_wr)
                prescale <= PW'(wr_data);
        end
    end

    // Sticky terminal flag; a same-cycle terminal event beats the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            term_flag <= 1'b0;
        else if (terminal)
            term_flag <= 1'b1;
        else if (flag_clr)
            term_flag <= 1'b0;
    end

    assign irq_src = term_flag && ctrl.irq_en;

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timer channels with a shared write port and combined irq.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter  int NUM_CHANNELS        = 4,
    parameter  int COUNTER_BIT_WIDTH   = 32,
    parameter  int PRESCALER_BIT_WIDTH = 16,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wr_en,
    input  logic [CH_W-1:0]                           wr_ch,
    input  logic [1:0]                                wr_addr,
    input  logic [COUNTER_BIT_WIDTH-1:0]              wr_data,
    input  logic [NUM_CHANNELS-1:0]                   flag_clr,
    output logic [NUM_CHANNELS*COUNTER_BIT_WIDTH-1:0] count_out,
    output logic [NUM_CHANNELS-1:0]                   match,
    output logic [NUM_CHANNELS-1:0]                   term_flag,
    output logic                                      irq
);

    logic [NUM_CHANNELS-1:0][COUNTER_BIT_WIDTH-1:0] cnt;
    logic [NUM_CHANNELS-1:0]                        wr_sel;
    logic [NUM_CHANNELS-1:0]                        irq_src;

    // Channel selects that do not exist never match any index, so they are dropped.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

        timer_channel #(
            .CW (COUNTER_BIT_WIDTH),
            .PW (PRESCALER_BIT_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_sel    (wr_sel[i]),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .flag_clr  (flag_clr[i]),
            .count     (cnt[i]),
            .match     (match[i]),
            .term_flag (term_flag[i]),
            .irq_src   (irq_src[i])
        );
    end

    // Packed array layout already places channel i at [i*W +: W].
    assign count_out = cnt;
    assign irq       = |irq_src;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (4 channels, 8-bit counters).
module tb_timer_bank;

    localparam int NC = 4;
    localparam int W  = 8;
    localparam logic [1:0] A_CTRL = 2'd0, A_LOAD = 2'd1, A_CMP = 2'd2, A_PRE = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [1:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [NC-1:0] flag_clr;
    logic [NC*W-1:0] count_out;
    logic [NC-1:0] match;
    logic [NC-1:0] term_flag;
    logic          irq;

    int checks = 0;
    int errors = 0;

    timer_bank #(
        .NUM_CHANNELS        (NC),
        .COUNTER_BIT_WIDTH   (W),
        .PRESCALER_BIT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flag_clr  (flag_clr),
        .count_out (count_out),
        .match     (match),
        .term_flag (term_flag),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // One table row is one clock edge: optional write/clear, then expected outputs.
    typedef struct {
        logic          we;
        logic [1:0]    ch;
        logic [1:0]    addr;
        logic [W-1:0]  data;
        logic [NC-1:0] clr;
        int            cc;
        logic [W-1:0]  cnt;
        logic [NC-1:0] flag;
        logic [NC-1:0] mt;
        logic          irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input int ch, input logic [1:0] addr,
                                input logic [W-1:0] data, input logic [NC-1:0] clr,
                                input int cc, input logic [W-1:0] cnt,
                                input logic [NC-1:0] flag, input logic [NC-1:0] mt,
                                input logic irq_e);
        vec_t v;
        v.we = we; v.ch = 2'(ch); v.addr = addr; v.data = data; v.clr = clr;
        v.cc = cc; v.cnt = cnt; v.flag = flag; v.mt = mt; v.irq = irq_e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] cnt_of(input int c);
        return count_out[c*W +: W];
    endfunction

    task automatic wr(input int ch, input logic [1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = a; wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0; flag_clr = '0;
        #1;
        chk("reset_count", 64'(count_out), 64'd0);
        chk("reset_match", 64'(match), 64'd0);
        chk("reset_flag", 64'(term_flag), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic count on ch0, prescale 0
        wr(0, A_PRE, 8'd0);
        wr(0, A_CTRL, 8'h01);
        chk("start_count", 64'(cnt_of(0)), 64'd0);
        step(100);
        chk("count100", 64'(cnt_of(0)), 64'd100);
        chk("others_idle", 64'(count_out[NC*W-1:W]), 64'd0);
        wr(0, A_CTRL, 8'h00);
        chk("disable_edge_step", 64'(cnt_of(0)), 64'd101);

        // Wrap up on ch1, irq enable, flag clear
        tbl.push_back(mk(1, 1, A_LOAD, 8'hFE, 4'h0, 1, 8'hFE, 4'h0, 4'h0, 0));
        tbl.push_back(mk(1, 1, A_CTRL, 8'h01, 4'h0, 1, 8'hFE, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 1, 8'hFF, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 1, 8'h00, 4'h2, 4'h2, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 1, 8'h01, 4'h2, 4'h0, 0));
        tbl.push_back(mk(1, 1, A_CTRL, 8'h11, 4'h0, 1, 8'h02, 4'h2, 4'h0, 1));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h2, 1, 8'h03, 4'h0, 4'h0, 0));
        tbl.push_back(mk(1, 1, A_CTRL, 8'h00, 4'h0, 1, 8'h04, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 1, 8'h04, 4'h0, 4'h0, 0));
        // One-shot down on ch2
        tbl.push_back(mk(1, 2, A_LOAD, 8'h03, 4'h0, 2, 8'h03, 4'h0, 4'h0, 0));
        tbl.push_back(mk(1, 2, A_CTRL, 8'h0B, 4'h0, 2, 8'h03, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h02, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h01, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h00, 4'h0, 4'h4, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h00, 4'h4, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h00, 4'h4, 4'h0, 0));
        tbl.push_back(mk(1, 2, A_LOAD, 8'h05, 4'h0, 2, 8'h05, 4'h4, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h05, 4'h4, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h4, 2, 8'h05, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 8'h00, 4'h0, 2, 8'h05, 4'h0, 4'h0, 0));

        foreach (tbl[r]) begin
            wr_en = tbl[r].we; wr_ch = tbl[r].ch; wr_addr = tbl[r].addr;
            wr_data = tbl[r].data; flag_clr = tbl[r].clr;
            @(posedge clk);
            @(negedge clk);
            wr_en = 1'b0; flag_clr = '0;
            chk($sformatf("row%0d_count", r), 64'(cnt_of(tbl[r].cc)), 64'(tbl[r].cnt));
            chk($sformatf("row%0d_flag", r), 64'(term_flag), 64'(tbl[r].flag));
            chk($sformatf("row%0d_match", r), 64'(match), 64'(tbl[r].mt));
            chk($sformatf("row%0d_irq", r), 64'(irq), 64'(tbl[r].irq));
        end

        // Prescale 4 and compare 3 on ch3: step every 5 edges, one match after the step to 3
        wr(3, A_PRE, 8'd4);
        wr(3, A_CMP, 8'd3);
        wr(3, A_CTRL, 8'h01);
        for (int c = 1; c <= 30; c++) begin
            step(1);
            chk($sformatf("pre_c%0d_count", c), 64'(cnt_of(3)), 64'(c / 5));
            chk($sformatf("pre_c%0d_match", c), 64'(match[3]), 64'(c == 15));
        end

        // LOAD on a tick edge wins; clear on a saturate terminal loses
        wr(0, A_CTRL, 8'h05);
        chk("sat_en_edge", 64'(cnt_of(0)), 64'd101);
        step(1);
        chk("sat_step", 64'(cnt_of(0)), 64'd102);
        wr(0, A_LOAD, 8'd50);
        chk("load_vs_tick", 64'(cnt_of(0)), 64'd50);
        step(1);
        chk("after_load", 64'(cnt_of(0)), 64'd51);
        wr(0, A_LOAD, 8'hFF);
        chk("load_ff", 64'(cnt_of(0)), 64'hFF);
        flag_clr = 4'h1;
        step(1);
        flag_clr = '0;
        chk("sat_hold", 64'(cnt_of(0)), 64'hFF);
        chk("set_beats_clr", 64'(term_flag[0]), 64'd1);
        chk("sat_no_match", 64'(match[0]), 64'd0);
        step(1);
        chk("sat_hold2", 64'(cnt_of(0)), 64'hFF);

        // Async reset between clock edges
        #2 rst = 1'b0;
        #1;
        chk("areset_count", 64'(count_out), 64'd0);
        chk("areset_flag", 64'(term_flag), 64'd0);
        chk("areset_match", 64'(match), 64'd0);
        chk("areset_irq", 64'(irq), 64'd0);
        #1 rst = 1'b1;
        step(10);
        chk("post_reset_idle", 64'(count_out), 64'd0);
        wr(0, A_CTRL, 8'h01);
        step(3);
        chk("restart_count", 64'(cnt_of(0)), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
